// File: rtl/mega_core.sv
// mega_core: single-cycle 8-bit core executing a subset of the AVR instruction set.
// The instruction word is decoded combinationally, and results commit on the rising clk edge.
// The I/O and data-memory strobes come straight from decode. They are gated by rst, so that
// reset silences the buses at once.
module mega_core #(
  parameter int bus_addr_pgm_width  = 11,
  parameter int bus_addr_data_width = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [bus_addr_pgm_width-1:0]  pgm_addr,
  input  logic [15:0]                    pgm_data,
  output logic                           data_re,
  output logic                           data_we,
  output logic [bus_addr_data_width-1:0] data_addr,
  input  logic [7:0]                     data_in,
  output logic [7:0]                     data_out,
  output logic                           io_re,
  output logic                           io_we,
  output logic [5:0]                     io_addr,
  output logic [7:0]                     io_out,
  input  logic [7:0]                     io_in
);

  localparam int PW = bus_addr_pgm_width;
  localparam int DW = bus_addr_data_width;

  logic [PW-1:0]     pc_reg, pc_next, pc_inc;
  logic [7:0]        reg_file [32];
  logic              c_reg, z_reg, n_reg, v_reg, s_reg;

  // Operand fields of the instruction word
  logic [4:0]        d_addr, r_addr, h_addr;
  logic [7:0]        rd_val, rr_val, rh_val, k8;
  logic [5:0]        a6;
  logic signed [11:0] k12;
  logic signed [6:0]  k7;

  // Decode results
  logic              wr_en, flag_zn, flag_c, c_new, v_new;
  logic [4:0]        wr_addr;
  logic [7:0]        res;
  logic              io_re_d, io_we_d, data_re_d, data_we_d;

  assign d_addr = pgm_data[8:4];
  assign r_addr = {pgm_data[9], pgm_data[3:0]};
  assign h_addr = {1'b1, pgm_data[7:4]};
  assign k8     = {pgm_data[11:8], pgm_data[3:0]};
  assign a6     = {pgm_data[10:9], pgm_data[3:0]};
  assign k12    = pgm_data[11:0];
  assign k7     = pgm_data[9:3];
  assign rd_val = reg_file[d_addr];
  assign rr_val = reg_file[r_addr];
  assign rh_val = reg_file[h_addr];
  assign pc_inc = pc_reg + PW'(1);

  // 8-bit add with carry-in; returns {carry, overflow, sum}
  function automatic logic [9:0] f_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + {8'h00, cin};
    return {s[8], (a[7] & b[7] & ~s[7]) | (~a[7] & ~b[7] & s[7]), s[7:0]};
  endfunction

  // 8-bit subtract; returns {borrow, overflow, difference}
  function automatic logic [9:0] f_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} - {1'b0, b};
    return {s[8], (a[7] & ~b[7] & ~s[7]) | (~a[7] & b[7] & s[7]), s[7:0]};
  endfunction

  // Instruction decode: write-back, flag updates, bus strobes and next PC
  always_comb begin
    pc_next   = pc_inc;
    wr_en     = 1'b0;
    wr_addr   = d_addr;
    res       = 8'h00;
    flag_zn   = 1'b0;
    flag_c    = 1'b0;
    c_new     = c_reg;
    v_new     = 1'b0;
    io_re_d   = 1'b0;
    io_we_d   = 1'b0;
    data_re_d = 1'b0;
    data_we_d = 1'b0;
    casez (pgm_data)
      16'b0000_11??_????_????: begin  // ADD
        {c_new, v_new, res} = f_add(rd_val, rr_val, 1'b0);
        flag_c = 1'b1; flag_zn = 1'b1; wr_en = 1'b1;
      end
      16'b0001_11??_????_????: begin  // ADC
        {c_new, v_new, res} = f_add(rd_val, rr_val, c_reg);
        flag_c = 1'b1; flag_zn = 1'b1; wr_en = 1'b1;
      end
      16'b0001_10??_????_????: begin  // SUB
        {c_new, v_new, res} = f_sub(rd_val, rr_val);
        flag_c = 1'b1; flag_zn = 1'b1; wr_en = 1'b1;
      end
      16'b0001_01??_????_????: begin  // CP
        {c_new, v_new, res} = f_sub(rd_val, rr_val);
        flag_c = 1'b1; flag_zn = 1'b1;
      end
      16'b0010_00??_????_????: begin res = rd_val & rr_val; flag_zn = 1'b1; wr_en = 1'b1; end  // AND
      16'b0010_01??_????_????: begin res = rd_val ^ rr_val; flag_zn = 1'b1; wr_en = 1'b1; end  // EOR
      16'b0010_10??_????_????: begin res = rd_val | rr_val; flag_zn = 1'b1; wr_en = 1'b1; end  // OR
      16'b0010_11??_????_????: begin res = rr_val; wr_en = 1'b1; end                            // MOV
      16'b0011_????_????_????: begin  // CPI
        {c_new, v_new, res} = f_sub(rh_val, k8);
        flag_c = 1'b1; flag_zn = 1'b1;
      end
      16'b0101_????_????_????: begin  // SUBI
        {c_new, v_new, res} = f_sub(rh_val, k8);
        flag_c = 1'b1; flag_zn = 1'b1; wr_en = 1'b1; wr_addr = h_addr;
      end
      16'b0110_????_????_????: begin res = rh_val | k8; flag_zn = 1'b1; wr_en = 1'b1; wr_addr = h_addr; end  // ORI
      16'b0111_????_????_????: begin res = rh_val & k8; flag_zn = 1'b1; wr_en = 1'b1; wr_addr = h_addr; end  // ANDI
      16'b1110_????_????_????: begin res = k8; wr_en = 1'b1; wr_addr = h_addr; end                           // LDI
      16'b1001_010?_????_0011: begin  // INC, carry untouched
        res = rd_val + 8'd1; v_new = (res == 8'h80); flag_zn = 1'b1; wr_en = 1'b1;
      end
      16'b1001_010?_????_1010: begin  // DEC, carry untouched
        res = rd_val - 8'd1; v_new = (res == 8'h7F); flag_zn = 1'b1; wr_en = 1'b1;
      end
      16'b1001_000?_????_1100: begin data_re_d = 1'b1; res = data_in; wr_en = 1'b1; end  // LD Rd,X
      16'b1001_001?_????_1100: data_we_d = 1'b1;                                          // ST X,Rr
      16'b1011_0???_????_????: begin io_re_d = 1'b1; res = io_in; wr_en = 1'b1; end      // IN
      16'b1011_1???_????_????: io_we_d = 1'b1;                                            // OUT
      16'b1100_????_????_????: pc_next = pc_inc + PW'(k12);                               // RJMP
      16'b1111_00??_????_?001: if (z_reg)  pc_next = pc_inc + PW'(k7);                    // BREQ
      16'b1111_01??_????_?001: if (!z_reg) pc_next = pc_inc + PW'(k7);                    // BRNE
      default: ;                                                                          // NOP / unsupported
    endcase
  end

  // Program counter: cleared by reset, otherwise takes the decoded next address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= '0;
    else      pc_reg <= pc_next;
  end

  // Status flags: S always follows the new N and V
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_reg <= 1'b0; z_reg <= 1'b0; n_reg <= 1'b0; v_reg <= 1'b0; s_reg <= 1'b0;
    end else begin
      if (flag_c) c_reg <= c_new;
      if (flag_zn) begin
        z_reg <= (res == 8'h00);
        n_reg <= res[7];
        v_reg <= v_new;
        s_reg <= res[7] ^ v_new;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi = gi + 1) begin : g_reg
      logic [7:0] q_reg;
      // Register gi loads the result when it is the write-back target
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               q_reg <= 8'h00;
        else if (wr_en && wr_addr == 5'(gi))   q_reg <= res;
      end
      assign reg_file[gi] = q_reg;
    end
  endgenerate

  assign pgm_addr  = pc_reg;
  assign io_re     = io_re_d & rst;
  assign io_we     = io_we_d & rst;
  assign data_re   = data_re_d & rst;
  assign data_we   = data_we_d & rst;
  assign io_addr   = (io_re_d | io_we_d) ? a6 : 6'h00;
  assign io_out    = io_we ? rd_val : 8'h00;
  assign data_out  = data_we ? rd_val : 8'h00;
  assign data_addr = DW'(reg_file[26]);

endmodule

// File: tb/tb_mega_core.sv
// tb_mega_core: directed programs for mega_core with hand-computed expected bus activity.
module tb_mega_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] pgm_addr;
  logic [15:0] pgm_data;
  logic        data_re, data_we, io_re, io_we;
  logic [7:0]  data_addr, data_in, data_out, io_out;
  logic [7:0]  io_in = 8'h00;
  logic [5:0]  io_addr;

  logic [15:0] prog [0:2047];
  logic [7:0]  ram  [0:255];
  int          n_vec = 0;
  int          n_err = 0;

  mega_core #(.bus_addr_pgm_width(11), .bus_addr_data_width(8)) dut (
    .clk(clk), .rst(rst), .pgm_addr(pgm_addr), .pgm_data(pgm_data),
    .data_re(data_re), .data_we(data_we), .data_addr(data_addr),
    .data_in(data_in), .data_out(data_out),
    .io_re(io_re), .io_we(io_we), .io_addr(io_addr), .io_out(io_out), .io_in(io_in)
  );

  always #5 clk = ~clk;

  assign pgm_data = prog[pgm_addr];
  assign data_in  = ram[data_addr];

  always @(posedge clk) if (data_we) ram[data_addr] <= data_out;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Instruction encoders
  function automatic logic [15:0] e_rr(input int op, input int d, input int r);
    logic [4:0] rr;
    rr = 5'(r);
    return {6'(op), rr[4], 5'(d), rr[3:0]};
  endfunction
  function automatic logic [15:0] e_imm(input int op, input int d, input int k);
    logic [7:0] kk;
    kk = 8'(k);
    return {4'(op), kk[7:4], 4'(d - 16), kk[3:0]};
  endfunction
  function automatic logic [15:0] e_one(input int pre, input int d, input int suf);
    return {7'(pre), 5'(d), 4'(suf)};
  endfunction
  function automatic logic [15:0] e_io(input int is_out, input int a, input int r);
    logic [5:0] aa;
    aa = 6'(a);
    return {4'b1011, 1'(is_out), aa[5:4], 5'(r), aa[3:0]};
  endfunction
  function automatic logic [15:0] e_rjmp(input int k);
    return {4'hC, 12'(k)};
  endfunction
  function automatic logic [15:0] e_br(input int ne, input int k);
    return {5'b11110, 1'(ne), 7'(k), 3'b001};
  endfunction

  localparam int ADD = 3, ADC = 7, SUB = 6, CP = 5, AND = 8, EOR = 9, OR = 10, MOV = 11;
  localparam int CPI = 3, SUBI = 5, ORI = 6, ANDI = 7, LDI = 14;

  // Unused program words decode as OUT 0x3F,r0 so any stray path shows on the bus.
  task automatic clear_prog();
    for (int i = 0; i < 2048; i++) prog[i] = e_io(1, 6'h3F, 0);
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    #1;
  endtask

  // Waits (bounded) for the next OUT cycle and checks where and what it writes.
  task automatic expect_out(input string tag, input int pc, input int a, input int v);
    int n;
    n = 0;
    while (io_we !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, int'(io_we), 1);
    chk({tag, "_pc"}, int'(pgm_addr), pc);
    chk({tag, "_addr"}, int'(io_addr), a);
    chk({tag, "_val"}, int'(io_out), v);
    @(negedge clk);
  endtask

  initial begin
    clear_prog();
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    #2 rst = 1'b0;
    @(negedge clk);

    // Reset state, with an OUT sitting at address 0
    chk("rst_pc", int'(pgm_addr), 0);
    chk("rst_io_we", int'(io_we), 0);
    chk("rst_io_out", int'(io_out), 0);
    chk("rst_data_we", int'(data_we), 0);

    // LDI then OUT
    prog[0] = e_imm(LDI, 16, 8'h5A);
    prog[1] = e_io(1, 0, 16);
    prog[2] = 16'h0000;
    release_reset();
    chk("c1_pc", int'(pgm_addr), 0);
    chk("c1_io_we", int'(io_we), 0);
    @(negedge clk);
    chk("c2_io_we", int'(io_we), 1);
    chk("c2_io_addr", int'(io_addr), 0);
    chk("c2_io_out", int'(io_out), 8'h5A);
    chk("c2_pc", int'(pgm_addr), 1);
    @(negedge clk);
    chk("c3_io_we", int'(io_we), 0);
    chk("c3_io_out", int'(io_out), 0);

    // IN then OUT
    hold_reset();
    clear_prog();
    io_in   = 8'hC3;
    prog[0] = e_io(0, 0, 17);
    prog[1] = e_io(1, 1, 17);
    release_reset();
    chk("in_io_re", int'(io_re), 1);
    chk("in_io_addr", int'(io_addr), 0);
    chk("in_io_we", int'(io_we), 0);
    @(negedge clk);
    chk("in_re_drop", int'(io_re), 0);
    expect_out("in_out", 1, 1, 8'hC3);

    // Arithmetic, flags and branches
    hold_reset();
    clear_prog();
    prog[0]  = e_imm(LDI, 16, 8'hFF);
    prog[1]  = e_imm(LDI, 17, 8'h01);
    prog[2]  = e_rr(ADD, 16, 17);       // r16=00 C=1 Z=1
    prog[3]  = e_br(0, 2);              // BREQ -> 6
    prog[6]  = e_io(1, 2, 16);
    prog[7]  = e_rr(ADC, 20, 20);       // r20=01 C=0 Z=0
    prog[8]  = e_io(1, 3, 20);
    prog[9]  = e_br(1, 5);              // BRNE -> 15
    prog[15] = e_io(1, 4, 20);
    prog[16] = e_imm(CPI, 20, 1);       // Z=1
    prog[17] = e_br(1, 3);              // BRNE not taken
    prog[18] = e_imm(SUBI, 20, 2);      // r20=FF C=1
    prog[19] = e_io(1, 5, 20);
    prog[20] = e_imm(LDI, 21, 0);
    prog[21] = e_rr(ADC, 21, 21);       // r21=01 C=0
    prog[22] = e_io(1, 6, 21);
    prog[23] = e_imm(LDI, 22, 8'hF0);
    prog[24] = e_imm(ANDI, 22, 8'h3C);  // 30
    prog[25] = e_imm(ORI, 22, 8'h05);   // 35
    prog[26] = e_io(1, 7, 22);
    prog[27] = e_rr(EOR, 22, 22);       // 00 Z=1
    prog[28] = e_br(0, 1);              // BREQ -> 30
    prog[30] = e_one(7'h4A, 22, 10);    // DEC -> FF
    prog[31] = e_io(1, 8, 22);
    prog[32] = e_imm(LDI, 23, 8'h80);
    prog[33] = e_rr(ADD, 23, 23);       // 00 C=1
    prog[34] = e_one(7'h4A, 22, 3);     // INC FF->00 Z=1, C kept
    prog[35] = e_br(0, 1);              // BREQ -> 37
    prog[37] = e_rr(ADC, 2, 2);         // 01
    prog[38] = e_io(1, 9, 2);
    prog[39] = e_imm(LDI, 24, 8'h10);
    prog[40] = e_imm(LDI, 25, 8'h20);
    prog[41] = e_rr(SUB, 24, 25);       // F0 C=1
    prog[42] = e_rr(CP, 25, 25);        // C=0, r25 kept
    prog[43] = e_rr(MOV, 3, 24);        // F0
    prog[44] = e_rr(ADC, 3, 3);         // E0
    prog[45] = e_io(1, 10, 3);
    prog[46] = e_io(1, 11, 25);
    prog[47] = e_rr(AND, 24, 25);       // 20
    prog[48] = e_rr(OR, 24, 17);        // 21
    prog[49] = e_io(1, 12, 24);
    prog[50] = e_rjmp(-1);
    release_reset();
    expect_out("add_breq", 6, 2, 8'h00);
    expect_out("adc_c1", 8, 3, 8'h01);
    expect_out("brne_tk", 15, 4, 8'h01);
    expect_out("subi", 19, 5, 8'hFF);
    expect_out("adc_c0", 22, 6, 8'h01);
    expect_out("andi_ori", 26, 7, 8'h35);
    expect_out("dec", 31, 8, 8'hFF);
    expect_out("inc_keep_c", 38, 9, 8'h01);
    expect_out("sub_cp_adc", 45, 10, 8'hE0);
    expect_out("cp_no_wr", 46, 11, 8'h20);
    expect_out("and_or", 49, 12, 8'h21);
    chk("rjmp_self", int'(pgm_addr), 50);
    repeat (3) @(negedge clk);
    chk("rjmp_loop", int'(pgm_addr), 50);

    // Store and load through X
    hold_reset();
    clear_prog();
    prog[0] = e_imm(LDI, 26, 8'h40);
    prog[1] = e_imm(LDI, 18, 8'h77);
    prog[2] = e_one(7'h49, 18, 12);
    prog[3] = e_one(7'h48, 19, 12);
    prog[4] = e_io(1, 0, 19);
    release_reset();
    repeat (2) @(negedge clk);
    chk("st_we", int'(data_we), 1);
    chk("st_re", int'(data_re), 0);
    chk("st_addr", int'(data_addr), 8'h40);
    chk("st_data", int'(data_out), 8'h77);
    @(negedge clk);
    chk("ld_re", int'(data_re), 1);
    chk("ld_we", int'(data_we), 0);
    chk("ld_addr", int'(data_addr), 8'h40);
    chk("ld_dout", int'(data_out), 0);
    expect_out("ld_out", 4, 0, 8'h77);

    // PC wrap on jumps and branches
    hold_reset();
    clear_prog();
    prog[0]     = e_rjmp(12'h7FE);      // -> 0x7FF
    prog[11'h7FF] = e_rjmp(1);          // -> 0x001 (wrap)
    prog[1]     = e_br(1, -3);          // BRNE -> 0x7FF (wrap back)
    release_reset();
    chk("wr_pc0", int'(pgm_addr), 0);
    @(negedge clk);
    chk("wr_7ff", int'(pgm_addr), 11'h7FF);
    @(negedge clk);
    chk("wr_fwd", int'(pgm_addr), 1);
    @(negedge clk);
    chk("wr_back", int'(pgm_addr), 11'h7FF);
    prog[11'h7FF] = e_rjmp(-1);
    repeat (3) @(negedge clk);
    chk("wr_loop", int'(pgm_addr), 11'h7FF);
    chk("wr_loop_we", int'(io_we), 0);

    // Reset during an OUT cycle
    hold_reset();
    clear_prog();
    prog[0] = e_imm(LDI, 16, 8'h5A);
    prog[1] = e_io(1, 0, 16);
    release_reset();
    @(negedge clk);
    chk("ab_out_we", int'(io_we), 1);
    rst = 1'b0;
    #1;
    chk("ab_we_drop", int'(io_we), 0);
    chk("ab_out_zero", int'(io_out), 0);
    chk("ab_pc", int'(pgm_addr), 0);
    prog[0] = e_io(1, 2, 16);
    prog[1] = 16'h0000;
    @(negedge clk);
    release_reset();
    chk("ab_re_we", int'(io_we), 1);
    chk("ab_re_addr", int'(io_addr), 2);
    chk("ab_re_r16", int'(io_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
